pc_unit: RTL and testbench

- Parametrised program-counter unit for the single-cycle and pipelined MIPS cores; successor to the fixed 32-bit reset/next register.
- Selects next PC internally by fixed priority from: exception entry, exception return (eret), branch/jump redirect, stall hold, return-address-stack (RAS) prediction, sequential increment.
- Holds EPC and a circular RAS of configurable depth; flags misaligned fetch addresses.

---
 rtl/pc_unit.sv | 109 ++++++++++
 tb/tb_pc_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: fixed-priority next-PC select, EPC capture and a
// circular return-address stack shared by the single-cycle and pipelined cores.
module pc_unit #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter int          STEP      = 4,
  parameter int          RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic             ras_push,
  input  logic             ras_pop,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic             misalign,
  output logic             ras_empty,
  output logic             ras_full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VEC);
  localparam logic [WIDTH-1:0] INC    = WIDTH'(STEP);
  localparam logic [CW-1:0]    FULL_C = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d;
  logic [PW-1:0]    ptr_q, ptr_d, ras_wa;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ras_we;
  logic [RAS_DEPTH-1:0][WIDTH-1:0] ras_q;

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign pc_plus   = pc_q + INC;
  assign misalign  = pc_q[1:0] != 2'b00;
  assign ras_empty = cnt_q == '0;
  assign ras_full  = cnt_q == FULL_C;

  always_comb begin
    pc_d   = pc_plus;
    epc_d  = epc_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    ras_we = 1'b0;
    ras_wa = ptr_q + PW'(1);
    if (exc_req) begin
      epc_d = pc_q;
      pc_d  = EXC_PC;
      cnt_d = '0;
      ptr_d = '0;
    end else if (eret) begin
      pc_d  = epc_q;
      cnt_d = '0;
      ptr_d = '0;
    end else if (br_taken) begin
      // Calls (jal/jalr) redirect and push in the same cycle.
      pc_d = br_target;
      if (ras_push) begin
        ras_we = 1'b1;
        ptr_d  = ptr_q + PW'(1);
        cnt_d  = ras_full ? cnt_q : cnt_q + CW'(1);
      end
    end else if (stall) begin
      pc_d = pc_q;
    end else if (ras_pop && !ras_empty) begin
      pc_d = ras_q[ptr_q];
      if (ras_push) begin
        // Return-then-call: swap the top entry in place.
        ras_we = 1'b1;
        ras_wa = ptr_q;
      end else begin
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
    end else if (ras_push) begin
      ras_we = 1'b1;
      ptr_d  = ptr_q + PW'(1);
      cnt_d  = ras_full ? cnt_q : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RST_PC;
      epc_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entries are don't-care after reset; validity is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (ras_we && !reset) ras_q[ras_wa] <= pc_plus;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed table-driven bench for pc_unit with default parameters.
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_taken, exc_req, eret, ras_push, ras_pop;
  logic [31:0] br_target;
  logic [31:0] pc, pc_plus, epc;
  logic        misalign, ras_empty, ras_full;

  int n_vec = 0;
  int n_err = 0;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .exc_req(exc_req), .eret(eret),
    .ras_push(ras_push), .ras_pop(ras_pop), .pc(pc), .pc_plus(pc_plus),
    .epc(epc), .misalign(misalign), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, br;
    logic [31:0] tgt;
    logic        ex, er, pu, po;
    logic [31:0] pc, epc;
    logic        em, fu, mi;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(logic st, logic br, logic [31:0] tgt, logic ex, logic er,
                            logic pu, logic po, logic [31:0] epc_x, logic [31:0] pc_x,
                            logic em, logic fu, logic mi);
    vec_t r;
    r.st = st; r.br = br; r.tgt = tgt; r.ex = ex; r.er = er; r.pu = pu; r.po = po;
    r.pc = pc_x; r.epc = epc_x; r.em = em; r.fu = fu; r.mi = mi;
    tbl.push_back(r);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [31:0] pc_x, logic [31:0] pcp_x, logic [31:0] epc_x,
                         logic em, logic fu, logic mi);
    chk({tag, ".pc"}, pc, pc_x);
    chk({tag, ".pc_plus"}, pc_plus, pcp_x);
    chk({tag, ".epc"}, epc, epc_x);
    chk({tag, ".empty"}, {31'b0, ras_empty}, {31'b0, em});
    chk({tag, ".full"}, {31'b0, ras_full}, {31'b0, fu});
    chk({tag, ".misalign"}, {31'b0, misalign}, {31'b0, mi});
  endtask

  task automatic idle_inputs();
    stall = 0; br_taken = 0; br_target = '0; exc_req = 0; eret = 0; ras_push = 0; ras_pop = 0;
  endtask

  initial begin
    //  st br tgt          ex er pu po  epc        pc           em fu mi
    v(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,    32'h3004,     1, 0, 0);
    v(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,    32'h3008,     1, 0, 0);
    v(1, 0, 32'h0,        0, 0, 0, 0, 32'h0,    32'h3008,     1, 0, 0);
    v(1, 0, 32'h0,        0, 0, 1, 0, 32'h0,    32'h3008,     1, 0, 0);
    v(1, 0, 32'h0,        0, 0, 0, 0, 32'h0,    32'h3008,     1, 0, 0);
    v(1, 1, 32'h3100,     0, 0, 0, 0, 32'h0,    32'h3100,     1, 0, 0);
    v(0, 1, 32'h300C,     0, 0, 0, 0, 32'h0,    32'h300C,     1, 0, 0);
    v(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,    32'h3010,     1, 0, 0);
    v(0, 0, 32'h0,        1, 1, 0, 0, 32'h3010, 32'h4180,     1, 0, 0);
    v(0, 0, 32'h0,        0, 0, 1, 0, 32'h3010, 32'h4184,     0, 0, 0);
    v(1, 0, 32'h0,        0, 1, 0, 0, 32'h3010, 32'h3010,     1, 0, 0);
    // RAS fill past depth, then drain
    v(0, 1, 32'h3000,     0, 0, 0, 0, 32'h3010, 32'h3000,     1, 0, 0);
    v(0, 1, 32'h3020,     0, 0, 1, 0, 32'h3010, 32'h3020,     0, 0, 0);
    v(0, 1, 32'h3040,     0, 0, 1, 0, 32'h3010, 32'h3040,     0, 0, 0);
    v(0, 1, 32'h3060,     0, 0, 1, 0, 32'h3010, 32'h3060,     0, 0, 0);
    v(0, 1, 32'h3080,     0, 0, 1, 0, 32'h3010, 32'h3080,     0, 1, 0);
    v(0, 1, 32'h3100,     0, 0, 1, 0, 32'h3010, 32'h3100,     0, 1, 0);
    v(0, 1, 32'h3300,     0, 0, 0, 1, 32'h3010, 32'h3300,     0, 1, 0);
    v(0, 0, 32'h0,        0, 0, 0, 1, 32'h3010, 32'h3084,     0, 0, 0);
    v(1, 0, 32'h0,        0, 0, 1, 1, 32'h3010, 32'h3084,     0, 0, 0);
    v(0, 0, 32'h0,        0, 0, 0, 1, 32'h3010, 32'h3064,     0, 0, 0);
    v(0, 0, 32'h0,        0, 0, 0, 1, 32'h3010, 32'h3044,     0, 0, 0);
    v(0, 0, 32'h0,        0, 0, 0, 1, 32'h3010, 32'h3024,     1, 0, 0);
    v(0, 0, 32'h0,        0, 0, 0, 1, 32'h3010, 32'h3028,     1, 0, 0);
    // push+pop swap, then push+pop on an empty stack
    v(0, 1, 32'h3100,     0, 0, 0, 0, 32'h3010, 32'h3100,     1, 0, 0);
    v(0, 1, 32'h3200,     0, 0, 1, 0, 32'h3010, 32'h3200,     0, 0, 0);
    v(0, 0, 32'h0,        0, 0, 1, 1, 32'h3010, 32'h3104,     0, 0, 0);
    v(0, 0, 32'h0,        0, 0, 0, 1, 32'h3010, 32'h3204,     1, 0, 0);
    v(0, 0, 32'h0,        0, 0, 1, 1, 32'h3010, 32'h3208,     0, 0, 0);
    v(0, 0, 32'h0,        0, 0, 0, 1, 32'h3010, 32'h3208,     1, 0, 0);
    // address wrap and misalignment
    v(0, 1, 32'hFFFFFFFC, 0, 0, 0, 0, 32'h3010, 32'hFFFFFFFC, 1, 0, 0);
    v(0, 0, 32'h0,        0, 0, 0, 0, 32'h3010, 32'h00000000, 1, 0, 0);
    v(0, 1, 32'h3102,     0, 0, 0, 0, 32'h3010, 32'h3102,     1, 0, 1);
    v(0, 0, 32'h0,        0, 0, 1, 0, 32'h3010, 32'h3106,     0, 0, 1);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 32'h3000, 32'h3004, 32'h0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      stall = tbl[i].st; br_taken = tbl[i].br; br_target = tbl[i].tgt;
      exc_req = tbl[i].ex; eret = tbl[i].er; ras_push = tbl[i].pu; ras_pop = tbl[i].po;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].pc + 32'd4, tbl[i].epc,
              tbl[i].em, tbl[i].fu, tbl[i].mi);
      @(negedge clk);
    end

    // Async reset mid-cycle with an exception and a push pending.
    exc_req = 1'b1; ras_push = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 32'h3000, 32'h3004, 32'h0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rst_hold", 32'h3000, 32'h3004, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_rst", 32'h3004, 32'h3008, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
